// File: rtl/la_pkg.sv
// Shared types and default sizes for the trig_capture_buffer logic-analyzer slice.
// The LA_TIMESTAMP_EN macro selects whether samples carry a timestamp.
package la_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        POST  = 2'd2,
        DONE  = 2'd3
    } la_state_t;

    localparam int LA_DATA_W = 256;
    localparam int LA_DEPTH  = 512;

`ifdef LA_TIMESTAMP_EN
    localparam bit LA_TS_EN = 1'b1;
`else
    localparam bit LA_TS_EN = 1'b0;
`endif

endpackage

// File: rtl/la_sample_ram.sv
// Simple dual-port sample RAM: one write port, one registered read-first read port.
// Kept behavioural so it can be swapped for a vendor macro of the same shape.
module la_sample_ram #(
    parameter int WIDTH  = 256,
    parameter int DEPTH  = 512,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WIDTH-1:0]  rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    // NOTE: the storage array is never reset, so it maps onto block RAM;
    // only the read register gets the asynchronous reset.
    always_ff @(posedge clk) begin
        if (we) mem[wr_addr] <= wr_data;
    end

    // Same-edge read of the address being written sees the old word.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) rd_data <= '0;
        else        rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/trig_capture_buffer.sv
// Triggered capture engine: circular sample RAM, masked/forced trigger, post-trigger
// count, logical-index readout. Define LA_TIMESTAMP_EN to store {ts, probe} per sample.
module trig_capture_buffer
    import la_pkg::*;
#(
    parameter int  DATA_W = LA_DATA_W,
    parameter int  DEPTH  = LA_DEPTH,
    parameter int  ADDR_W = $clog2(DEPTH),
    parameter int  TS_W   = 32,
    localparam int RD_W   = DATA_W + (LA_TS_EN ? TS_W : 0)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] probe,
    input  logic              arm,
    input  logic              force_trig,
    input  logic [DATA_W-1:0] trig_mask,
    input  logic [DATA_W-1:0] trig_value,
    input  logic [ADDR_W-1:0] post_len,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [RD_W-1:0]   rd_data,
    output logic [1:0]        state,
    output logic [ADDR_W:0]   sample_cnt,
    output logic [ADDR_W-1:0] trig_index
);

    localparam logic [ADDR_W:0] FULL = (ADDR_W+1)'(DEPTH);

    la_state_t         state_q, state_nxt;
    logic [DATA_W-1:0] probe_q;
    logic              arm_q, first_q, first_nxt;
    logic [ADDR_W-1:0] wr_ptr, wr_ptr_nxt;
    logic [ADDR_W:0]   cnt_nxt;
    logic [ADDR_W-1:0] post_cnt, post_nxt;
    logic [ADDR_W-1:0] trig_phys, trig_phys_nxt, trig_index_nxt;
    logic [ADDR_W-1:0] oldest, oldest_nxt, rd_phys;
    logic              we, clear, hit, arm_rise;
    logic [RD_W-1:0]   wr_word;

    assign hit      = ((probe_q ^ trig_value) & trig_mask) == '0;
    assign arm_rise = arm & ~arm_q;
    assign state    = state_q;

    // NOTE: every always_comb output gets a default first so no path leaves
    // a variable unassigned, which would otherwise infer a latch.
    always_comb begin
        state_nxt     = state_q;
        we            = 1'b0;
        clear         = 1'b0;
        first_nxt     = 1'b0;
        post_nxt      = post_cnt;
        trig_phys_nxt = trig_phys;
        if (!arm) begin
            state_nxt = IDLE;
        end else begin
            unique case (state_q)
                IDLE: if (arm_rise) begin
                    state_nxt = ARMED;
                    clear     = 1'b1;
                    first_nxt = 1'b1;
                    post_nxt  = '0;
                end
                ARMED: begin
                    we = 1'b1;
                    if (!first_q && (hit || force_trig)) begin
                        trig_phys_nxt = wr_ptr;
                        // post_len is ADDR_W wide, so it never exceeds DEPTH-1
                        post_nxt      = post_len;
                        state_nxt     = (post_len == '0) ? DONE : POST;
                    end
                end
                POST: begin
                    we       = 1'b1;
                    post_nxt = post_cnt - ADDR_W'(1);
                    if (post_cnt == ADDR_W'(1)) state_nxt = DONE;
                end
                DONE:    ;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        wr_ptr_nxt = wr_ptr;
        cnt_nxt    = sample_cnt;
        if (clear) begin
            wr_ptr_nxt = '0;
            cnt_nxt    = '0;
        end else if (we) begin
            wr_ptr_nxt = wr_ptr + ADDR_W'(1);
            if (sample_cnt != FULL) cnt_nxt = sample_cnt + (ADDR_W+1)'(1);
        end
    end

    // trig_index is taken relative to the oldest sample as it stands after the final write
    assign oldest_nxt     = (cnt_nxt == FULL) ? wr_ptr_nxt : '0;
    assign trig_index_nxt = (state_nxt == DONE && state_q != DONE)
                            ? trig_phys_nxt - oldest_nxt : trig_index;

    assign oldest  = (sample_cnt == FULL) ? wr_ptr : '0;
    assign rd_phys = oldest + rd_addr;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            probe_q    <= '0;
            arm_q      <= 1'b0;
            first_q    <= 1'b0;
            wr_ptr     <= '0;
            sample_cnt <= '0;
            post_cnt   <= '0;
            trig_phys  <= '0;
            trig_index <= '0;
        end else begin
            state_q    <= state_nxt;
            probe_q    <= probe;
            arm_q      <= arm;
            first_q    <= first_nxt;
            wr_ptr     <= wr_ptr_nxt;
            sample_cnt <= cnt_nxt;
            post_cnt   <= post_nxt;
            trig_phys  <= trig_phys_nxt;
            trig_index <= trig_index_nxt;
        end
    end

`ifdef LA_TIMESTAMP_EN
    logic [TS_W-1:0] ts;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)        ts <= '0;
        else if (arm_rise) ts <= '0;
        else               ts <= ts + TS_W'(1);
    end

    // Stored stamp is the cycle count since arming, so the first sample carries 1
    assign wr_word = {ts + TS_W'(1), probe_q};
`else
    assign wr_word = probe_q;
`endif

    la_sample_ram #(
        .WIDTH (RD_W),
        .DEPTH (DEPTH),
        .ADDR_W(ADDR_W)
    ) u_ram (
        .clk    (clk),
        .reset  (reset),
        .we     (we),
        .wr_addr(wr_ptr),
        .wr_data(wr_word),
        .rd_addr(rd_phys),
        .rd_data(rd_data)
    );

endmodule
